// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per-frame snapshot of object slots, background clear, then one draw request per non-empty slot
module sprite_draw_sequencer #(
    parameter int NUM_SLOTS = 6,
    parameter int CODE_W    = 5,
    parameter int POS_W     = 17
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [NUM_SLOTS*CODE_W-1:0]   obj_code,
    input  logic [NUM_SLOTS*POS_W-1:0]    obj_pos,
    output logic                          clear_start,
    input  logic                          clear_done,
    output logic                          draw_valid,
    input  logic                          draw_ready,
    output logic [CODE_W-1:0]             draw_code,
    output logic [8:0]                    draw_x,
    output logic [7:0]                    draw_y,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int IW = $clog2(NUM_SLOTS);
    localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);

    logic [2:0]                  state_q, state_d;
    logic [IW-1:0]               slot_idx_q, slot_idx_d;
    logic [NUM_SLOTS*CODE_W-1:0] code_sh_q, code_sh_d;
    logic [NUM_SLOTS*POS_W-1:0]  pos_sh_q, pos_sh_d;
    logic                        clear_start_q, clear_start_d;
    logic                        draw_valid_q, draw_valid_d;
    logic [CODE_W-1:0]           draw_code_q, draw_code_d;
    logic [8:0]                  draw_x_q, draw_x_d;
    logic [7:0]                  draw_y_q, draw_y_d;
    logic                        busy_q, busy_d;
    logic                        frame_done_q, frame_done_d;
    logic                        overrun_q, overrun_d;
    logic [CODE_W-1:0]           cur_code;
    logic [POS_W-1:0]            cur_pos;

    assign cur_code    = code_sh_q[slot_idx_q*CODE_W +: CODE_W];
    assign cur_pos     = pos_sh_q[slot_idx_q*POS_W +: POS_W];
    assign clear_start = clear_start_q;
    assign draw_valid  = draw_valid_q;
    assign draw_code   = draw_code_q;
    assign draw_x      = draw_x_q;
    assign draw_y      = draw_y_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

    // Frame FSM: snapshot, clear, walk slots in order issuing one handshake per non-empty slot
    always_comb begin
        state_d       = state_q;
        slot_idx_d    = slot_idx_q;
        code_sh_d     = code_sh_q;
        pos_sh_d      = pos_sh_q;
        clear_start_d = 1'b0;
        draw_valid_d  = draw_valid_q;
        draw_code_d   = draw_code_q;
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        overrun_d     = frame_start && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (frame_start) begin
                code_sh_d     = obj_code;
                pos_sh_d      = obj_pos;
                slot_idx_d    = '0;
                busy_d        = 1'b1;
                clear_start_d = 1'b1;
                state_d       = S_CLEAR;
            end
            S_CLEAR: state_d = clear_done ? S_SCAN : S_CLEAR;
            S_SCAN: if (cur_code != '0) begin
                draw_valid_d = 1'b1;
                draw_code_d  = cur_code;
                draw_x_d     = cur_pos[16:8];
                draw_y_d     = cur_pos[7:0];
                state_d      = S_DRAW;
            end else if (slot_idx_q == LAST) begin
                state_d = S_DONE;
            end else begin
                slot_idx_d = slot_idx_q + 1'b1;
            end
            S_DRAW: if (draw_ready) begin
                draw_valid_d = 1'b0;
                state_d      = (slot_idx_q == LAST) ? S_DONE : S_SCAN;
                slot_idx_d   = (slot_idx_q == LAST) ? slot_idx_q : slot_idx_q + 1'b1;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops everything, including a pending draw
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            slot_idx_q    <= '0;
            code_sh_q     <= '0;
            pos_sh_q      <= '0;
            clear_start_q <= 1'b0;
            draw_valid_q  <= 1'b0;
            draw_code_q   <= '0;
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_idx_q    <= slot_idx_d;
            code_sh_q     <= code_sh_d;
            pos_sh_q      <= pos_sh_d;
            clear_start_q <= clear_start_d;
            draw_valid_q  <= draw_valid_d;
            draw_code_q   <= draw_code_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
        end
    end
endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb_sprite_draw_sequencer: directed and randomized frames checked against a slot-list reference model
module tb_sprite_draw_sequencer;
    logic         CLOCK_50 = 1'b0;
    logic         reset, frame_start, clear_done, draw_ready;
    logic [29:0]  obj_code;
    logic [101:0] obj_pos;
    logic         clear_start, draw_valid, busy, frame_done, overrun;
    logic [4:0]   draw_code;
    logic [8:0]   draw_x;
    logic [7:0]   draw_y;
    int           errors = 0;
    int           checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    sprite_draw_sequencer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_start(frame_start),
        .obj_code(obj_code), .obj_pos(obj_pos), .clear_start(clear_start),
        .clear_done(clear_done), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_code(draw_code), .draw_x(draw_x), .draw_y(draw_y), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge CLOCK_50);
    endtask

    function automatic logic [26:0] all_outs();
        return {clear_start, draw_valid, draw_code, draw_x, draw_y, busy, frame_done, overrun};
    endfunction

    // mode 0: ready tied high; 1: random ready; 2: ready low for the first 10 valid cycles
    task automatic run_frame(input logic [29:0] c, input logic [101:0] p, input int dly,
                             input int mode, input bit inj);
        logic [21:0] exp_q[$];
        logic [21:0] last;
        int cs_k = -1, clr_k = -1, ne = 0, e = 0, n_cs = 0, n_ov = 0, n_inj = 0, hold = 0;
        bit done = 0, pend = 0, first_v = 1;
        for (int i = 0; i < 6; i++) begin
            if (c[5*i +: 5] != 5'd0) begin
                exp_q.push_back({c[5*i +: 5], p[17*i+8 +: 9], p[17*i +: 8]});
                ne++;
            end else e++;
        end
        obj_code = c; obj_pos = p; frame_start = 1; draw_ready = 0; clear_done = 0;
        step;
        frame_start = 0;
        for (int k = 1; k < 400 && !done; k++) begin
            if (clear_start) begin n_cs++; cs_k = k; end
            if (overrun) n_ov++;
            if (frame_done) begin
                done = 1;
                chk("busy_end", 32'(busy), 0);
                chk("draws_left", exp_q.size(), 0);
                if (mode == 0) chk("latency", k, clr_k + 2*ne + e + 2);
            end else chk("busy", 32'(busy), 1);
            if (pend) begin
                chk("hold_valid", 32'(draw_valid), 1);
                chk("hold_fields", 32'({draw_code, draw_x, draw_y}), 32'(last));
            end
            clear_done = (cs_k > 0 && k == cs_k + dly);
            if (clear_done) clr_k = k;
            frame_start = inj && (k == 1 || (draw_valid && first_v));
            if (frame_start) n_inj++;
            if (mode == 0) draw_ready = 1;
            else if (mode == 1) draw_ready = 1'($urandom_range(0, 1));
            else draw_ready = (hold >= 10);
            if (draw_valid) begin
                first_v = 0;
                hold++;
                if (draw_ready) begin
                    chk("draw_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("draw", 32'({draw_code, draw_x, draw_y}), 32'(exp_q.pop_front()));
                    pend = 0;
                end else begin
                    pend = 1;
                    last = {draw_code, draw_x, draw_y};
                end
            end
            obj_code = 30'($urandom);
            obj_pos = 102'({$urandom, $urandom, $urandom, $urandom});
            step;
        end
        if (!done) chk("timeout", 0, 1);
        chk("clear_count", n_cs, 1);
        chk("overrun_count", n_ov, n_inj);
        chk("done_one_cycle", 32'({frame_done, clear_start, draw_valid, busy}), 0);
        frame_start = 0; draw_ready = 0; clear_done = 0;
    endtask

    function automatic logic [29:0] rand_codes(input bit slot0_full);
        logic [29:0] c;
        for (int i = 0; i < 6; i++) c[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
        if (slot0_full) c[4:0] = 5'($urandom_range(1, 31));
        return c;
    endfunction

    initial begin
        logic [101:0] p;
        bit found;
        reset = 1; frame_start = 0; clear_done = 0; draw_ready = 0; obj_code = '0; obj_pos = '0;
        step; step;
        chk("reset_outputs", 32'(all_outs()), 0);
        reset = 0;
        step;
        // mixed empty/non-empty slots, slot0 position fixed
        p = 102'({$urandom, $urandom, $urandom, $urandom});
        p[16:0] = 17'h01A30;
        run_frame({5'd7, 5'd0, 5'd12, 5'd0, 5'd0, 5'd4}, p, 3, 0, 0);
        // all slots empty
        run_frame(30'd0, 102'({$urandom, $urandom, $urandom, $urandom}), 2, 0, 0);
        // stalled handshake on slot 0
        run_frame(rand_codes(1), 102'({$urandom, $urandom, $urandom, $urandom}), 2, 2, 0);
        // frame_start during CLEAR and during DRAW
        run_frame(rand_codes(1), 102'({$urandom, $urandom, $urandom, $urandom}), 4, 0, 1);
        // reset while slot 3 is pending
        obj_code = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        obj_pos = 102'({$urandom, $urandom, $urandom, $urandom});
        frame_start = 1; step; frame_start = 0;
        clear_done = 1; step; clear_done = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (draw_valid && draw_code == 5'd4) found = 1;
            else begin draw_ready = 1; step; end
        end
        draw_ready = 0;
        chk("slot3_reached", 32'(found), 1);
        #2 reset = 1;
        #1 chk("async_reset_outputs", 32'(all_outs()), 0);
        step; reset = 0; step;
        run_frame({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 102'({$urandom, $urandom, $urandom, $urandom}), 1, 0, 0);
        // randomized frames
        for (int f = 0; f < 10; f++)
            run_frame(rand_codes(0), 102'({$urandom, $urandom, $urandom, $urandom}),
                      $urandom_range(1, 5), 1, 1'($urandom_range(0, 1)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
